updown_mod_counter: RTL
=======================

# updown_mod_counter

Parametrised synchronous up/down counter with programmable terminal value, synchronous clear, parallel load, terminal-count flag and registered wrap pulse. It is the general-purpose successor to the fixed 3-bit enable-gated up-counter. It sits under the tester's timing and sequencing logic as a divider, sample counter or address generator.

## Interface
- WIDTH, 8: counter width in bits; legal 1..32.
- MAX_COUNT, 2**WIDTH-1: highest count value; sequence is 0..MAX_COUNT; must satisfy 0 < MAX_COUNT <= 2**WIDTH-1.
- RESET_VALUE, 0: count value after reset and after clear; must be <= MAX_COUNT.
- clock  in  1  rising-edge clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  count advances one step per cycle while high.
- clear  in  1  synchronous clear to RESET_VALUE.
- load  in  1  synchronous parallel load.
- load_value  in  WIDTH  value taken on load.
- up_down  in  1  direction; 1 = up, 0 = down.
- count  out  WIDTH  registered count.
- terminal  out  1  combinational; high when the next enabled step would cross the bound.
- wrap  out  1  registered one-cycle pulse, high the cycle after a wrap occurred.

## Operation
- Priority per cycle: clear > load > enable > hold.
- clear: count <= RESET_VALUE; wrap <= 0. Ignores enable, load and up_down.
- load: count <= min(load_value, MAX_COUNT); out-of-range values clamp to MAX_COUNT. wrap <= 0.
- enable, up: count == MAX_COUNT gives count <= 0 and wrap <= 1; otherwise count + 1.
- enable, down: count == 0 gives count <= MAX_COUNT and wrap <= 1; otherwise count - 1.
- enable low, no clear/load: count holds; wrap <= 0.
- terminal = (up_down && count == MAX_COUNT) || (!up_down && count == 0). It is independent of enable.
- Arithmetic is WIDTH bits internally. Bound compares are done before increment, so no carry or borrow ever reaches count.
- up_down may change any cycle. The step taken uses the value sampled on that edge.

## Timing
- Reset (asynchronous assert, any time, including mid-count): count = RESET_VALUE and wrap = 0 immediately. terminal follows combinationally.
- Reset release: first count step on the first rising edge with reset_n high and enable high.
- Latency: 1 cycle from sampled clear/load/enable to the updated count.
- wrap: asserted exactly one cycle, aligned with the wrapped count value. Consecutive wraps (for example MAX_COUNT = 1) give wrap high on consecutive cycles.
- clear or load in the same cycle as a wrap condition: the wrap is suppressed.

## Configuration
- COUNTER_SATURATE_EN, when defined:
  - Enabled steps at the bound hold the count: up at MAX_COUNT stays at MAX_COUNT; down at 0 stays at 0.
  - wrap is tied 0.
  - terminal is unchanged.
- COUNTER_SATURATE_EN, when undefined: wrap-around behaviour as in Operation.

## Structure
- counter_pkg holds:
  - typedef dir_e: DIR_DOWN = 1'b0, DIR_UP = 1'b1.
  - Parameter-legality check helper function.
- Single module, no sub-module. Next-state logic is one combinational block feeding one asynchronous-reset register block for count and wrap.
- Elaboration-time assertions on WIDTH, MAX_COUNT and RESET_VALUE.

## Test plan
- Reset: WIDTH=4, MAX_COUNT=9, RESET_VALUE=3; pulse reset_n low mid-count at count=7 -> count=3 and wrap=0 asynchronously, before the next edge.
- Up wrap: enable=1, up_down=1 from 0 for 12 cycles -> count 0..9, 0, 1. wrap high only on the cycle count shows 0 after 9. terminal high while count=9.
- Down wrap: up_down=0 from count=1 -> 1, 0, 9, 8. wrap pulses with 9. terminal high at 0.
- Priority: clear=1, load=1, load_value=5, enable=1 together -> count=RESET_VALUE (3). Next cycle load=1 only -> 5. Next cycle load_value=15 -> clamped to 9, wrap=0.
- Hold and direction change: enable=0 for 3 cycles at count=4 -> count stays 4. Toggle up_down each cycle with enable=1 from 4 -> 5, 4, 5, 4.
- With COUNTER_SATURATE_EN defined, MAX_COUNT=9: count up from 8 for 4 cycles -> 9, 9, 9, 9, wrap stays 0. Count down from 1 -> 0, 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and the parameter-legality helper for updown_mod_counter.
// Optional feature macro used by the counter: COUNTER_SATURATE_EN.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // True when the counter parameters describe a realisable counter.
  function automatic bit counter_params_ok(input int unsigned    width,
                                           input longint unsigned max_count,
                                           input longint unsigned reset_value);
    longint unsigned lim;
    if (width < 1 || width > 32) return 1'b0;
    lim = (64'd1 << width) - 64'd1;
    return (max_count > 0) && (max_count <= lim) && (reset_value <= max_count);
  endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with clear, clamped load, terminal flag and wrap pulse.
// Define COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter longint unsigned MAX_COUNT   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VALUE = 64'd0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_C = RESET_VALUE[WIDTH-1:0];

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_mod_counter: WIDTH %0d outside 1..32", WIDTH);
  end
  if (!counter_params_ok(WIDTH, MAX_COUNT, RESET_VALUE)) begin : g_bad_params
    $error("updown_mod_counter: illegal MAX_COUNT %0d / RESET_VALUE %0d for WIDTH %0d",
           MAX_COUNT, RESET_VALUE, WIDTH);
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  dir_e             dir;

  assign dir      = dir_e'(up_down);
  assign terminal = ((dir == DIR_UP)   && (count_q == MAX_C)) ||
                    ((dir == DIR_DOWN) && (count_q == '0));

  // Bound is tested before stepping, so the +1/-1 never carries or borrows out.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = RST_C;
    end else if (load) begin
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
    end else if (enable) begin
      if (terminal) begin
`ifdef COUNTER_SATURATE_EN
        count_d = count_q;
`else
        count_d = (dir == DIR_UP) ? '0 : MAX_C;
        wrap_d  = 1'b1;
`endif
      end else begin
        count_d = (dir == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RST_C;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
